pe_b_fetch_ctrl: RTL and testbench
==================================

Name: pe_b_fetch_ctrl

Overview:
Upstream feeder for the PE B-operand register. Fetches a programmed number of 4-element B vectors from a synchronous-read memory. Presents each element as a registered word with a load strobe and a 3-bit element index, in the format the PE B-register consumes. After each complete vector, holds a valid/ready handshake with the PE before fetching the next vector.

Parameters:
DATA_W, 16, element width (matches PE d_in)
ADDR_W, 8, memory address width
MEM_LAT, 1, memory read latency in cycles (only 1 supported; fixed constant)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a fetch run; sampled only in IDLE
base_addr  in  ADDR_W  address of first element; captured on accepted start
num_vecs  in  8  number of 4-element vectors to fetch; captured on accepted start
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  DATA_W  memory data, valid the cycle after mem_rd_en is high
d_out  out  DATA_W  element to PE (drives PE d_in)
load_en  out  1  element strobe to PE
elem_cnt  out  3  element index to PE; 0..7, wraps; values 0 and 4 mark vector start
vec_valid  out  1  complete vector is resident in the PE register
pe_ready  in  1  PE has consumed the current vector
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, internal counters 0. Reset mid-run aborts immediately, with no further reads or loads.
- All outputs are registered.
- FSM states are IDLE, READ, WAIT_ACK, FIN.
- IDLE:
  - On start=1, capture base_addr and num_vecs, clear elem_cnt, set busy.
  - If num_vecs==0, go to FIN. Otherwise go to READ.
- READ:
  - Issues exactly 4 consecutive reads: mem_rd_en=1 with mem_addr=A, A+1, A+2, A+3.
  - The address counter wraps modulo 2^ADDR_W.
  - After the 4th read, go to WAIT_ACK.
- Data path:
  - Read issued in cycle k returns data in k+1.
  - d_out<=mem_rd_data and load_en<=1 are visible in cycle k+2.
  - Latency from read to load is 2 cycles.
  - elem_cnt on a load equals that element's running index mod 8; it advances after each load.
- vec_valid:
  - Set on the edge after the load whose elem_cnt[1:0]==3.
  - Cleared on the edge where vec_valid&&pe_ready.
  - pe_ready while vec_valid=0 is ignored.
- WAIT_ACK:
  - Waits for vec_valid&&pe_ready.
  - Then decrements the remaining-vector count. If vectors remain, go to READ, continuing from the next address. Otherwise go to FIN.
- FIN: done=1 for one cycle, busy cleared in the same edge, return to IDLE.
- start asserted while busy is ignored.
- start and pe_ready both high in IDLE: start accepted, pe_ready ignored.
- elem_cnt is not reset between vectors within a run, so successive vectors alternate start indices 0 and 4.

Decomposition:
- Shared package pe_pkg holds:
  - DATA_W and ELEMS_PER_VEC=4
  - the FSM state enum (IDLE/READ/WAIT_ACK/FIN)
  - ELEM_CNT_W=3
- One natural sub-module, pe_b_rd_pipe: the 2-stage register pipeline aligning mem_rd_data, load_en and elem_cnt.
- FSM and address/vector counters stay in the top.

Test Plan:
- Basic run:
  - Stimulus: memory[i]=16'h1000+i; start with base_addr=8'h10, num_vecs=1; pe_ready=1.
  - Response: reads 0x10..0x13; loads d_out 1010,1011,1012,1013 with elem_cnt 0,1,2,3; vec_valid one cycle; done pulse; busy drops.
- Multi-vector with stall:
  - Stimulus: num_vecs=3; pe_ready held low 5 cycles after each vec_valid.
  - Response: no mem_rd_en while vec_valid&&!pe_ready; elem_cnt runs 0..7 then 0..3; 12 loads total; a single done pulse.
- Address wrap:
  - Stimulus: base_addr=8'hFE, num_vecs=1.
  - Response: mem_addr FE, FF, 00, 01.
- Zero length:
  - Stimulus: num_vecs=0.
  - Response: no reads or loads; busy high one cycle, then done pulse the next cycle.
- Reset mid-run:
  - Stimulus: assert rst during the 2nd read of vector 2.
  - Response: all outputs 0 asynchronously; FSM returns to IDLE; a subsequent start runs cleanly from elem_cnt=0.
- Spurious inputs:
  - Stimulus: start pulses while busy, and pe_ready=1 with vec_valid=0.
  - Response: no effect on counters, addresses or state.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and FSM encoding for the PE B-operand fetch path.
package pe_pkg;

   localparam int unsigned DATA_W        = 16;
   localparam int unsigned ELEMS_PER_VEC = 4;
   localparam int unsigned ELEM_CNT_W    = 3;
   localparam int unsigned MEM_LAT       = 1;

   typedef logic [1:0] fsm_state_t;

   localparam fsm_state_t IDLE     = 2'd0;
   localparam fsm_state_t READ     = 2'd1;
   localparam fsm_state_t WAIT_ACK = 2'd2;
   localparam fsm_state_t FIN      = 2'd3;

endpackage

// File: rtl/pe_b_fetch_ctrl_if.sv
// Control, memory-read and PE-load signals of the B-operand fetch controller.
interface pe_b_fetch_ctrl_if #(
   parameter int unsigned DATA_W = pe_pkg::DATA_W,
   parameter int unsigned ADDR_W = 8
);

   logic                          start;
   logic [ADDR_W-1:0]             base_addr;
   logic [7:0]                    num_vecs;
   logic                          mem_rd_en;
   logic [ADDR_W-1:0]             mem_addr;
   logic [DATA_W-1:0]             mem_rd_data;
   logic [DATA_W-1:0]             d_out;
   logic                          load_en;
   logic [pe_pkg::ELEM_CNT_W-1:0] elem_cnt;
   logic                          vec_valid;
   logic                          pe_ready;
   logic                          busy;
   logic                          done;

   modport slave (
      input  start, base_addr, num_vecs, mem_rd_data, pe_ready,
      output mem_rd_en, mem_addr, d_out, load_en, elem_cnt, vec_valid, busy, done
   );

   modport master (
      output start, base_addr, num_vecs, mem_rd_data, pe_ready,
      input  mem_rd_en, mem_addr, d_out, load_en, elem_cnt, vec_valid, busy, done
   );

endinterface

// File: rtl/pe_b_rd_pipe.sv
// Two-stage alignment of memory read data into registered PE load word,
// strobe and running element index.
module pe_b_rd_pipe #(
   parameter int unsigned DATA_W = pe_pkg::DATA_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rd_en_i,
   input  logic [DATA_W-1:0]             rd_data_i,
   input  logic                          clr_i,
   output logic [DATA_W-1:0]             d_out_o,
   output logic                          load_en_o,
   output logic [pe_pkg::ELEM_CNT_W-1:0] elem_cnt_o
);

   import pe_pkg::*;

   logic                  rd_vld_q;
   logic [DATA_W-1:0]     data_q;
   logic                  load_q;
   logic [ELEM_CNT_W-1:0] cnt_q, cnt_d;

   // Index stays on the current element during its load and steps afterwards.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_q) begin
         cnt_d = cnt_q + ELEM_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld_q <= 1'b0;
         data_q   <= '0;
         load_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         rd_vld_q <= rd_en_i;
         load_q   <= rd_vld_q;
         if (rd_vld_q) begin
            data_q <= rd_data_i;
         end
         cnt_q    <= cnt_d;
      end
   end

   assign d_out_o    = data_q;
   assign load_en_o  = load_q;
   assign elem_cnt_o = cnt_q;

endmodule

// File: rtl/pe_b_fetch_ctrl.sv
// Fetches num_vecs 4-element B vectors from memory into the PE B-register,
// handshaking each complete vector with the PE before fetching the next.
module pe_b_fetch_ctrl #(
   parameter int unsigned DATA_W = pe_pkg::DATA_W,
   parameter int unsigned ADDR_W = 8
) (
   input logic               clk,
   input logic               rst,
   pe_b_fetch_ctrl_if.slave  bus
);

   import pe_pkg::*;

   fsm_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        vecs_q, vecs_d;
   logic [1:0]        rd_cnt_q, rd_cnt_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              vec_valid_q, vec_valid_d;
   logic              start_acc;
   logic              ack;

   logic [DATA_W-1:0]     pipe_d_out;
   logic                  pipe_load_en;
   logic [ELEM_CNT_W-1:0] pipe_elem_cnt;

   assign ack = vec_valid_q & bus.pe_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      vecs_d      = vecs_q;
      rd_cnt_d    = rd_cnt_q;
      rd_en_d     = rd_en_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      start_acc   = 1'b0;
      vec_valid_d = vec_valid_q;

      if (ack) begin
         vec_valid_d = 1'b0;
      end else if (pipe_load_en && (pipe_elem_cnt[1:0] == 2'(ELEMS_PER_VEC - 1))) begin
         vec_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               start_acc = 1'b1;
               busy_d    = 1'b1;
               vecs_d    = bus.num_vecs;
               if (bus.num_vecs == 8'd0) begin
                  state_d = FIN;
               end else begin
                  state_d  = READ;
                  rd_en_d  = 1'b1;
                  addr_d   = bus.base_addr;
                  rd_cnt_d = 2'd0;
               end
            end
         end
         READ: begin
            if (rd_cnt_q == 2'(ELEMS_PER_VEC - 1)) begin
               rd_en_d = 1'b0;
               state_d = WAIT_ACK;
            end else begin
               addr_d   = addr_q + ADDR_W'(1);
               rd_cnt_d = rd_cnt_q + 2'd1;
            end
         end
         WAIT_ACK: begin
            if (ack) begin
               vecs_d = vecs_q - 8'd1;
               if (vecs_q == 8'd1) begin
                  state_d = FIN;
               end else begin
                  // Next vector continues right after the last address read.
                  state_d  = READ;
                  rd_en_d  = 1'b1;
                  addr_d   = addr_q + ADDR_W'(1);
                  rd_cnt_d = 2'd0;
               end
            end
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         vecs_q      <= '0;
         rd_cnt_q    <= '0;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         vec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         vecs_q      <= vecs_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         vec_valid_q <= vec_valid_d;
      end
   end

   pe_b_rd_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .clk        (clk),
      .rst        (rst),
      .rd_en_i    (rd_en_q),
      .rd_data_i  (bus.mem_rd_data),
      .clr_i      (start_acc),
      .d_out_o    (pipe_d_out),
      .load_en_o  (pipe_load_en),
      .elem_cnt_o (pipe_elem_cnt)
   );

   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_addr  = addr_q;
   assign bus.d_out     = pipe_d_out;
   assign bus.load_en   = pipe_load_en;
   assign bus.elem_cnt  = pipe_elem_cnt;
   assign bus.vec_valid = vec_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_pe_b_fetch_ctrl.sv
// Directed self-checking bench for pe_b_fetch_ctrl with a 1-cycle memory model.
module tb_pe_b_fetch_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pe_b_fetch_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

   pe_b_fetch_ctrl #(
      .DATA_W (16),
      .ADDR_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem [256];
   always @(posedge clk or posedge rst) begin
      if (rst) bus.mem_rd_data <= 16'h0;
      else if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
   end

   int checks = 0;
   int errors = 0;

   logic [7:0]  rd_q [$];
   logic [15:0] ld_d [$];
   logic [2:0]  ld_c [$];
   int          n_done = 0;
   int          n_stall_rd = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_rd_en) rd_q.push_back(bus.mem_addr);
         if (bus.load_en) begin
            ld_d.push_back(bus.d_out);
            ld_c.push_back(bus.elem_cnt);
         end
         if (bus.done) n_done++;
         if (bus.mem_rd_en && bus.vec_valid && !bus.pe_ready) n_stall_rd++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic clr_mon();
      rd_q.delete();
      ld_d.delete();
      ld_c.delete();
      n_done     = 0;
      n_stall_rd = 0;
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      while (!bus.done && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(tag, {31'd0, bus.done}, 32'd1);
   endtask

   function automatic logic [31:0] all_outs();
      return {bus.mem_rd_en, bus.mem_addr, bus.d_out, bus.load_en, bus.elem_cnt,
              bus.vec_valid, bus.busy, bus.done};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      bus.start     = 1'b0;
      bus.base_addr = 8'h00;
      bus.num_vecs  = 8'd0;
      bus.pe_ready  = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      #10;
      chk("reset_outputs", all_outs(), 32'h0);
      drv();
      rst = 1'b0;

      // Basic run, pe_ready held high (also high in IDLE alongside start)
      drv();
      bus.base_addr = 8'h10;
      bus.num_vecs  = 8'd1;
      bus.pe_ready  = 1'b1;
      bus.start     = 1'b1;
      drv();
      bus.start = 1'b0;
      nxt();
      chk("basic_c1_rd", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h110);
      chk("basic_c1_busy", {31'd0, bus.busy}, 32'd1);
      nxt();
      chk("basic_c2_rd", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h111);
      nxt();
      chk("basic_c3_rd", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h112);
      chk("basic_c3_ld", {12'd0, bus.load_en, bus.elem_cnt, bus.d_out}, 32'h8_1010);
      nxt();
      chk("basic_c4_rd", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h113);
      chk("basic_c4_ld", {12'd0, bus.load_en, bus.elem_cnt, bus.d_out}, 32'h9_1011);
      nxt();
      chk("basic_c5_rd_off", {31'd0, bus.mem_rd_en}, 32'd0);
      chk("basic_c5_ld", {12'd0, bus.load_en, bus.elem_cnt, bus.d_out}, 32'hA_1012);
      nxt();
      chk("basic_c6_ld", {12'd0, bus.load_en, bus.elem_cnt, bus.d_out}, 32'hB_1013);
      chk("basic_c6_vv", {31'd0, bus.vec_valid}, 32'd0);
      nxt();
      chk("basic_c7_ld_off", {31'd0, bus.load_en}, 32'd0);
      chk("basic_c7_vv", {31'd0, bus.vec_valid}, 32'd1);
      nxt();
      chk("basic_c8_fin", {29'd0, bus.vec_valid, bus.busy, bus.done}, 32'b010);
      nxt();
      chk("basic_c9_done", {30'd0, bus.busy, bus.done}, 32'b01);
      nxt();
      chk("basic_c10_idle", {30'd0, bus.busy, bus.done}, 32'b00);
      chk("basic_elem_after", {29'd0, bus.elem_cnt}, 32'd4);

      // Three vectors, 5-cycle PE stall each, spurious start while busy
      drv();
      clr_mon();
      bus.pe_ready  = 1'b0;
      bus.base_addr = 8'h20;
      bus.num_vecs  = 8'd3;
      bus.start     = 1'b1;
      drv();
      bus.start = 1'b0;
      for (int v = 0; v < 3; v++) begin
         int t = 0;
         while (!bus.vec_valid && t < 100) begin
            @(negedge clk);
            t++;
         end
         chk("multi_vec_valid_seen", {31'd0, bus.vec_valid}, 32'd1);
         for (int s = 0; s < 5; s++) begin
            drv();
            bus.start     = (s == 0);
            bus.base_addr = 8'h90;
            bus.num_vecs  = 8'd7;
         end
         drv();
         bus.start    = 1'b0;
         bus.pe_ready = 1'b1;
         drv();
         bus.pe_ready = 1'b0;
      end
      wait_done("multi_done");
      repeat (3) nxt();
      chk("multi_rd_count", rd_q.size(), 32'd12);
      chk("multi_ld_count", ld_d.size(), 32'd12);
      for (int i = 0; i < 12; i++) begin
         if (i < rd_q.size()) chk("multi_rd_addr", {24'd0, rd_q[i]}, 32'h20 + 32'(i));
         if (i < ld_d.size()) begin
            chk("multi_ld_data", {16'd0, ld_d[i]}, 32'h1020 + 32'(i));
            chk("multi_ld_cnt", {29'd0, ld_c[i]}, 32'(i % 8));
         end
      end
      chk("multi_done_pulses", n_done, 32'd1);
      chk("multi_no_rd_in_stall", n_stall_rd, 32'd0);
      chk("multi_busy_off", {31'd0, bus.busy}, 32'd0);

      // Address wrap
      drv();
      clr_mon();
      bus.pe_ready  = 1'b1;
      bus.base_addr = 8'hFE;
      bus.num_vecs  = 8'd1;
      bus.start     = 1'b1;
      drv();
      bus.start = 1'b0;
      wait_done("wrap_done");
      chk("wrap_rd_count", rd_q.size(), 32'd4);
      if (rd_q.size() == 4) begin
         chk("wrap_addrs", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, 32'hFEFF_0001);
      end
      if (ld_d.size() == 4) begin
         chk("wrap_data_lo", {ld_d[0], ld_d[1]}, 32'h10FE_10FF);
         chk("wrap_data_hi", {ld_d[2], ld_d[3]}, 32'h1000_1001);
      end

      // Zero-length run
      drv();
      clr_mon();
      bus.base_addr = 8'h40;
      bus.num_vecs  = 8'd0;
      bus.start     = 1'b1;
      drv();
      bus.start = 1'b0;
      nxt();
      chk("zero_c1", {30'd0, bus.busy, bus.done}, 32'b10);
      nxt();
      chk("zero_c2", {30'd0, bus.busy, bus.done}, 32'b01);
      nxt();
      chk("zero_c3", {30'd0, bus.busy, bus.done}, 32'b00);
      chk("zero_no_rd", rd_q.size(), 32'd0);
      chk("zero_no_ld", ld_d.size(), 32'd0);

      // Reset during the 2nd read of vector 2
      drv();
      bus.base_addr = 8'h50;
      bus.num_vecs  = 8'd3;
      bus.start     = 1'b1;
      drv();
      bus.start = 1'b0;
      begin
         int t = 0;
         while (!(bus.mem_rd_en && bus.mem_addr == 8'h55) && t < 100) begin
            @(negedge clk);
            t++;
         end
         chk("rstmid_reached", {23'd0, bus.mem_rd_en, bus.mem_addr}, 32'h155);
      end
      rst = 1'b1;
      #1;
      chk("rstmid_outputs", all_outs(), 32'h0);
      drv();
      clr_mon();
      rst = 1'b0;
      repeat (3) nxt();
      chk("rstmid_quiet_rd", rd_q.size(), 32'd0);
      chk("rstmid_quiet_ld", ld_d.size(), 32'd0);
      drv();
      bus.base_addr = 8'h60;
      bus.num_vecs  = 8'd1;
      bus.start     = 1'b1;
      drv();
      bus.start = 1'b0;
      wait_done("rstmid_rerun_done");
      if (ld_c.size() == 4) begin
         chk("rstmid_rerun_cnt", {20'd0, ld_c[0], ld_c[1], ld_c[2], ld_c[3]}, 32'o0123);
         chk("rstmid_rerun_d0", {16'd0, ld_d[0]}, 32'h1060);
      end else begin
         chk("rstmid_rerun_ld_count", ld_c.size(), 32'd4);
      end

      // pe_ready with no vector resident, while idle
      drv();
      clr_mon();
      bus.pe_ready = 1'b1;
      repeat (4) drv();
      bus.pe_ready = 1'b0;
      nxt();
      chk("spur_ready_state", {28'd0, bus.elem_cnt, bus.busy}, {28'd0, 3'd4, 1'b0});
      chk("spur_ready_vv", {31'd0, bus.vec_valid}, 32'd0);
      chk("spur_ready_no_rd", rd_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
